// File: rtl/store_narrow_32to16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_narrow_pkg
// Description : Shared encodings for the 32->16 store narrowing bridge:
//               store size codes, FSM state codes, lane-enable levels and
//               the alignment check helper.
// Revision    : 1.0 - initial release
// ============================================================================
package store_narrow_pkg;

    // CPU store size encodings
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // Bridge FSM state encodings
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_beat1 = 2'd1;
    localparam logic [1:0] c_st_beat2 = 2'd2;
    localparam logic [1:0] c_st_err   = 2'd3;

    // SRAM byte lanes are enabled by driving them low
    localparam logic c_lane_on  = 1'b0;
    localparam logic c_lane_off = 1'b1;

    // A store is illegal if its address is not a multiple of its size,
    // or if it uses the reserved size code.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        case (size)
            SIZE_BYTE: r = 1'b0;
            SIZE_HALF: r = addr_lo[0];
            SIZE_WORD: r = |addr_lo;
            default:   r = 1'b1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_narrow_32to16_lane_pack.sv
`default_nettype none
// ============================================================================
// Module      : store_lane_pack
// Description : Combinational big-endian lane packer. Maps a store request
//               (size, low address bits, 32-bit right-justified data) and a
//               beat select onto 16-bit SRAM data plus active-low byte
//               lane enables. Even byte address lands in the upper lane.
// Revision    : 1.0 - initial release
// ============================================================================
module store_lane_pack
    import store_narrow_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_data,
    input  logic        i_beat_sel,   // 0 = first beat, 1 = second word beat
    output logic [15:0] o_sram_data,
    output logic        o_ub_n,
    output logic        o_lb_n,
    output logic        o_misaligned
);

    // Select data half and lane enables for the requested beat
    always_comb begin
        o_sram_data  = 16'h0000;
        o_ub_n       = c_lane_off;
        o_lb_n       = c_lane_off;
        o_misaligned = is_misaligned(i_size, i_addr_lo);
        if (i_beat_sel) begin
            // second half of a word: low halfword, both lanes
            o_sram_data = i_data[15:0];
            o_ub_n      = c_lane_on;
            o_lb_n      = c_lane_on;
        end else begin
            case (i_size)
                SIZE_BYTE: begin
                    // replicate so either lane carries the byte
                    o_sram_data = {i_data[7:0], i_data[7:0]};
                    if (i_addr_lo[0]) begin
                        o_lb_n = c_lane_on;
                    end else begin
                        o_ub_n = c_lane_on;
                    end
                end
                SIZE_HALF: begin
                    o_sram_data = i_data[15:0];
                    o_ub_n      = c_lane_on;
                    o_lb_n      = c_lane_on;
                end
                SIZE_WORD: begin
                    o_sram_data = i_data[31:16];
                    o_ub_n      = c_lane_on;
                    o_lb_n      = c_lane_on;
                end
                default: begin
                    o_sram_data = 16'h0000;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_narrow_32to16.sv
`default_nettype none
// ============================================================================
// Module      : store_narrow_32to16
// Description : MEM-stage store bridge. Accepts byte/half/word CPU stores and
//               issues them as one or two halfword beats on a 16-bit SRAM
//               write port (big-endian). Misaligned or reserved-size stores
//               produce a one-cycle storeError pulse and no SRAM beat.
//               Optional macro STORE_NARROW_BUFFER_EN adds a one-entry
//               request buffer so a store can be accepted while busy and
//               launched with no idle bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module store_narrow_32to16
    import store_narrow_pkg::*;
#(
    parameter int ADDR_WIDTH = 18
)
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  storeValid,
    output logic                  storeReady,
    input  logic [31:0]           storeAddress,
    input  logic [31:0]           storeData,
    input  logic [1:0]            storeSize,
    output logic                  storeError,
    output logic                  sramReq,
    input  logic                  sramAck,
    output logic [ADDR_WIDTH-1:0] sramAddr,
    output logic [15:0]           sramData,
    output logic                  sramUB_n,
    output logic                  sramLB_n,
    output logic                  sramWE_n
);

    localparam logic [ADDR_WIDTH-1:0] c_hw_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic                  r_req;
    logic                  r_err;
    logic                  r_ub_n;
    logic                  r_lb_n;
    logic                  r_cap_word;
    logic [15:0]           r_cap_lo;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_data;

    logic                  w_idle;
    logic                  w_hs;
    logic                  w_done;
    logic                  w_to_beat2;
    logic                  w_launch;
    logic [1:0]            w_src_size;
    logic [ADDR_WIDTH:0]   w_src_addr;
    logic [31:0]           w_src_data;

    logic [1:0]            w_pk_size;
    logic [1:0]            w_pk_addr_lo;
    logic [31:0]           w_pk_data;
    logic [15:0]           w_pk_sram_data;
    logic                  w_pk_ub_n;
    logic                  w_pk_lb_n;
    logic                  w_pk_mis;

    // Address bits above the SRAM halfword range are discarded
    logic                  w_unused;
    assign w_unused = &{1'b0, storeAddress[31:ADDR_WIDTH+1]};

    assign w_idle     = (r_state == c_st_idle);
    assign w_hs       = storeValid & storeReady;
    assign w_to_beat2 = (r_state == c_st_beat1) & sramAck & r_cap_word;
    assign w_done     = ((r_state == c_st_beat1) & sramAck & ~r_cap_word)
                      | ((r_state == c_st_beat2) & sramAck)
                      |  (r_state == c_st_err);

`ifdef STORE_NARROW_BUFFER_EN
    logic                  r_buf_valid;
    logic [1:0]            r_buf_size;
    logic [ADDR_WIDTH:0]   r_buf_addr;
    logic [31:0]           r_buf_data;

    assign storeReady = ~r_buf_valid;
    // A held request always takes priority over a fresh one at completion
    assign w_src_size = r_buf_valid ? r_buf_size : storeSize;
    assign w_src_addr = r_buf_valid ? r_buf_addr : storeAddress[ADDR_WIDTH:0];
    assign w_src_data = r_buf_valid ? r_buf_data : storeData;
    assign w_launch   = (w_idle & w_hs) | (w_done & (r_buf_valid | w_hs));

    // Hold a request accepted while a transfer is still in progress
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_buf_valid <= 1'b0;
            r_buf_size  <= SIZE_BYTE;
            r_buf_addr  <= '0;
            r_buf_data  <= 32'h0;
        end else if (w_done & r_buf_valid) begin
            r_buf_valid <= 1'b0;
        end else if (w_hs & ~w_idle & ~w_done) begin
            r_buf_valid <= 1'b1;
            r_buf_size  <= storeSize;
            r_buf_addr  <= storeAddress[ADDR_WIDTH:0];
            r_buf_data  <= storeData;
        end
    end
`else
    assign storeReady = w_idle;
    assign w_src_size = storeSize;
    assign w_src_addr = storeAddress[ADDR_WIDTH:0];
    assign w_src_data = storeData;
    assign w_launch   = w_idle & w_hs;
`endif

    // Beat 2 of a word and a new launch never coincide, so one packer serves both
    assign w_pk_size    = w_to_beat2 ? SIZE_WORD            : w_src_size;
    assign w_pk_addr_lo = w_to_beat2 ? 2'b00                : w_src_addr[1:0];
    assign w_pk_data    = w_to_beat2 ? {16'h0000, r_cap_lo} : w_src_data;

    store_lane_pack u_lane_pack (
        .i_size       (w_pk_size),
        .i_addr_lo    (w_pk_addr_lo),
        .i_data       (w_pk_data),
        .i_beat_sel   (w_to_beat2),
        .o_sram_data  (w_pk_sram_data),
        .o_ub_n       (w_pk_ub_n),
        .o_lb_n       (w_pk_lb_n),
        .o_misaligned (w_pk_mis)
    );

    // Bridge FSM with registered SRAM-side outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= c_st_idle;
            r_req      <= 1'b0;
            r_err      <= 1'b0;
            r_ub_n     <= c_lane_off;
            r_lb_n     <= c_lane_off;
            r_addr     <= '0;
            r_data     <= 16'h0000;
            r_cap_word <= 1'b0;
            r_cap_lo   <= 16'h0000;
        end else if (w_launch) begin
            r_cap_lo   <= w_src_data[15:0];
            r_cap_word <= (w_src_size == SIZE_WORD);
            if (w_pk_mis) begin
                r_state <= c_st_err;
                r_err   <= 1'b1;
                r_req   <= 1'b0;
                r_ub_n  <= c_lane_off;
                r_lb_n  <= c_lane_off;
            end else begin
                r_state <= c_st_beat1;
                r_err   <= 1'b0;
                r_req   <= 1'b1;
                r_addr  <= w_src_addr[ADDR_WIDTH:1];
                r_data  <= w_pk_sram_data;
                r_ub_n  <= w_pk_ub_n;
                r_lb_n  <= w_pk_lb_n;
            end
        end else if (w_to_beat2) begin
            // beat-1 halfword address is even, so +1 cannot carry out
            r_state <= c_st_beat2;
            r_addr  <= r_addr + c_hw_one;
            r_data  <= w_pk_sram_data;
            r_ub_n  <= w_pk_ub_n;
            r_lb_n  <= w_pk_lb_n;
        end else if (w_done) begin
            r_state <= c_st_idle;
            r_req   <= 1'b0;
            r_err   <= 1'b0;
            r_ub_n  <= c_lane_off;
            r_lb_n  <= c_lane_off;
        end
    end

    assign storeError = r_err;
    assign sramReq    = r_req;
    assign sramWE_n   = ~r_req;
    assign sramAddr   = r_addr;
    assign sramData   = r_data;
    assign sramUB_n   = r_ub_n;
    assign sramLB_n   = r_lb_n;

endmodule
`default_nettype wire
